// File: rtl/clk_gate_sequencer.sv
// clk_gate_sequencer: applies requested clock-enable changes one gate at a time, waiting for idle before stopping a clock.
module clk_gate_sequencer #(
  parameter int N_GATES = 32,
  parameter logic [N_GATES-1:0] RESET_EN = {N_GATES{1'b1}},
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [N_GATES-1:0] clk_gate_req_i,
  input  logic [N_GATES-1:0] periph_idle_i,
  input  logic [N_GATES-1:0] err_clr_i,
  output logic [N_GATES-1:0] clk_en_o,
  output logic [N_GATES-1:0] err_o,
  output logic               busy_o
);
  localparam int IW = N_GATES > 1 ? $clog2(N_GATES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ENABLE, WAIT_IDLE, SETTLE} state_t;
  state_t state, nstate;
  logic [IW-1:0] idx, nidx, win;
  logic [TW-1:0] tcnt, ntcnt;
  logic [SW-1:0] scnt, nscnt;
  logic [N_GATES-1:0] mis, nen, nerr;
  assign busy_o = state != IDLE;
  always_comb begin
    mis = (clk_gate_req_i ^ clk_en_o) & ~err_o;
    win = '0;
    for (int i = N_GATES - 1; i >= 0; i--) if (mis[i]) win = IW'(i);
    nstate = state;
    nidx = idx;
    ntcnt = tcnt;
    nscnt = scnt;
    nen = clk_en_o;
    // a timeout set in this cycle overrides a coincident clear
    nerr = err_o & ~err_clr_i;
    case (state)
      IDLE: if (|mis) begin
        nidx = win;
        ntcnt = '0;
        nstate = clk_gate_req_i[win] ? ENABLE : WAIT_IDLE;
      end
      ENABLE: begin
        nen[idx] = 1'b1;
        nscnt = '0;
        nstate = SETTLE;
      end
      WAIT_IDLE: if (clk_gate_req_i[idx]) nstate = IDLE;
      else if (periph_idle_i[idx]) begin
        nen[idx] = 1'b0;
        nscnt = '0;
        nstate = SETTLE;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        nerr[idx] = 1'b1;
        nstate = IDLE;
      end else ntcnt = tcnt + 1'b1;
      SETTLE: if (scnt == SW'(SETTLE_CYCLES - 1)) nstate = IDLE;
      else nscnt = scnt + 1'b1;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
      idx <= '0;
      tcnt <= '0;
      scnt <= '0;
      clk_en_o <= RESET_EN;
      err_o <= '0;
    end else begin
      state <= nstate;
      idx <= nidx;
      tcnt <= ntcnt;
      scnt <= nscnt;
      clk_en_o <= nen;
      err_o <= nerr;
    end
  end
endmodule
